uart_rx: RTL and testbench

- UART receiver with 16x oversampling.
- Sits directly downstream of the baud tick generator. It consumes that generator's one-clock sample tick and the serial rx line, then deframes start, data, optional parity and stop bits.
- It delivers a parallel byte with a one-cycle done strobe, plus frame and parity error flags, to the RX FIFO / host interface.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: encodings and oversampling constants shared by uart_rx and uart_tx.
//   OVERSAMPLE - s_tick strobes per bit period
//   MID_TICK   - tick index at the middle of the start bit
//   LAST_TICK  - tick index at the middle of a data/parity bit (one full period)
//   rx_state_t - receiver FSM state encoding
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int LAST_TICK  = 15;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and parallel-side outputs of the UART receiver.
//   rx, s_tick                              - serial line and oversample strobe
//   rx_done_tick, rx_dout, frame_err,
//   parity_err                              - received word and status
// master: the receiver. slave: whoever drives the line/tick and consumes the word.
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] rx_dout;
  logic            frame_err;
  logic            parity_err;

  modport master (
    input  rx, s_tick,
    output rx_done_tick, rx_dout, frame_err, parity_err
  );

  modport slave (
    output rx, s_tick,
    input  rx_done_tick, rx_dout, frame_err, parity_err
  );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: generic two-flop synchronizer for an asynchronous single-bit input.
//   clk, reset_n - clock, async active-low reset (both flops load RST_VAL)
//   i_d          - asynchronous input
//   o_q          - synchronized output, 2 clk latency
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, DBIT data LSB first,
// optional parity, stop).
//   clk, reset_n - clock, async active-low reset
//   bus (master) - rx/s_tick in; rx_done_tick/rx_dout/frame_err/parity_err out
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data
// bits (sense set by PARITY_ODD); otherwise parity_err is constant 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.master bus
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            w_rx_s;
  rx_state_t       r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_dout;
  logic            r_done, r_ferr, r_perr;
  logic            w_fire, w_perr_calc;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic            r_par, w_par_nxt;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (bus.rx),
    .o_q    (w_rx_s)
  );

  // State register plus the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_done  <= w_fire;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
      if (w_fire) begin
        r_dout <= r_b;
        r_ferr <= ~w_rx_s;
        r_perr <= w_perr_calc;
      end
    end
  end

  // Next-state logic. IDLE ignores s_tick so the start edge is seen on the
  // first clk after it reaches rx_s, including right after a STOP exit.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      RX_IDLE:
        if (!w_rx_s) w_state_nxt = RX_START;
      RX_START:
        if (bus.s_tick) begin
          if (r_s == S_MID) w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
          else              w_s_nxt     = r_s + 1'b1;
        end
      RX_DATA:
        if (bus.s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST)
`ifdef UART_RX_PARITY_EN
              w_state_nxt = RX_PARITY;
`else
              w_state_nxt = RX_STOP;
`endif
            else
              w_n_nxt = r_n + 1'b1;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
      RX_PARITY:
        if (bus.s_tick) begin
          if (r_s == S_LAST) begin
            w_par_nxt   = w_rx_s;
            w_state_nxt = RX_STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
`endif
      RX_STOP:
        if (bus.s_tick) begin
          if (r_s == S_STOP) w_state_nxt = RX_IDLE;
          else               w_s_nxt     = r_s + 1'b1;
        end
      default:
        w_state_nxt = RX_IDLE;
    endcase
    // Counters restart on every state entry.
    if (w_state_nxt != r_state) begin
      w_s_nxt = '0;
      w_n_nxt = '0;
    end
  end

  // Output logic: completion strobe and the parity verdict it latches.
  always_comb begin
    w_fire = (r_state == RX_STOP) && bus.s_tick && (r_s == S_STOP);
`ifdef UART_RX_PARITY_EN
    w_perr_calc = r_par != ((^r_b) ^ ODD);
`else
    w_perr_calc = 1'b0;
`endif
  end

  assign bus.rx_done_tick = r_done;
  assign bus.rx_dout      = r_dout;
  assign bus.frame_err    = r_ferr;
  assign bus.parity_err   = r_perr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a frame-level model (queue of
// expected words built from what is sent) is checked every clk, plus literal
// checkpoints after each scenario.
module tb_uart_rx;

  localparam int DBIT = 8;
  localparam int DVSR = 53;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 176;
`else
  localparam int FRAME_TICKS = 160;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DBIT(DBIT)) bus();

  uart_rx #(.DBIT(DBIT), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Baud generator: one s_tick every DVSR+1 clocks.
  int dcnt = 0;
  always @(posedge clk) begin
    if (dcnt == DVSR) begin
      dcnt       <= 0;
      bus.s_tick <= 1'b1;
    end else begin
      dcnt       <= dcnt + 1;
      bus.s_tick <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  // Written by stimulus only.
  exp_t       exp_a[32];
  int         wr_idx = 0;
  bit         pin_req = 1'b0;
  int         pin_kind = 0;
  string      pin_name = "";
  logic [7:0] pin_dout = 8'h00;
  logic       pin_fe = 1'b0;
  logic       pin_pe = 1'b0;
  int         to_cnt = 0;

  // Written by the compare process only.
  int         n_vec = 0;
  int         n_bad = 0;
  int         rd_idx = 0;
  int         done_cnt = 0;
  int         to_seen = 0;
  bit         pin_ack = 1'b0;
  longint     cyc = 0;
  longint     last_done = 0;
  longint     prev_done = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;

  task automatic show_bad(string name, logic [7:0] d, logic fe, logic pe);
    n_bad++;
    $display("FAIL %s: got done=%b dout=%02h ferr=%b perr=%b, want done=0/1 dout=%02h ferr=%b perr=%b",
             name, bus.rx_done_tick, bus.rx_dout, bus.frame_err, bus.parity_err, d, fe, pe);
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    n_vec++;
    if (!reset_n) begin
      m_dout = 8'h00; m_fe = 1'b0; m_pe = 1'b0;
      rd_idx = wr_idx;
      if (bus.rx_done_tick !== 1'b0 || bus.rx_dout !== 8'h00 ||
          bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0)
        show_bad("reset_outputs", 8'h00, 1'b0, 1'b0);
    end else if (bus.rx_done_tick === 1'b1) begin
      if (rd_idx < wr_idx) begin
        m_dout = exp_a[rd_idx].d; m_fe = exp_a[rd_idx].fe; m_pe = exp_a[rd_idx].pe;
        rd_idx++;
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        if (bus.rx_dout !== m_dout || bus.frame_err !== m_fe || bus.parity_err !== m_pe)
          show_bad("frame_word", m_dout, m_fe, m_pe);
      end else begin
        show_bad("unexpected_done", m_dout, m_fe, m_pe);
      end
    end else if (bus.rx_done_tick !== 1'b0 || bus.rx_dout !== m_dout ||
                 bus.frame_err !== m_fe || bus.parity_err !== m_pe) begin
      show_bad("held_outputs", m_dout, m_fe, m_pe);
    end

    if (pin_req != pin_ack) begin
      pin_ack = pin_req;
      n_vec++;
      case (pin_kind)
        0: if (bus.rx_done_tick !== 1'b0 || bus.rx_dout !== pin_dout ||
               bus.frame_err !== pin_fe || bus.parity_err !== pin_pe)
             show_bad(pin_name, pin_dout, pin_fe, pin_pe);
        1: if (rd_idx != wr_idx) begin
             n_bad++;
             $display("FAIL %s: frames completed %0d, required %0d", pin_name, rd_idx, wr_idx);
           end
        default: if (last_done - prev_done < longint'(FRAME_TICKS * (DVSR + 1))) begin
             n_bad++;
             $display("FAIL %s: done spacing %0d clk, required >= %0d", pin_name,
                      last_done - prev_done, FRAME_TICKS * (DVSR + 1));
           end
      endcase
    end

    if (to_cnt != to_seen) begin
      to_seen = to_cnt;
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got done count %0d, required more", done_cnt);
    end
  end

  task automatic pin(int kind, string name, logic [7:0] d, logic fe, logic pe);
    pin_kind = kind; pin_name = name; pin_dout = d; pin_fe = fe; pin_pe = pe;
    pin_req = ~pin_req;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Returns just after the DUT has consumed n s_ticks.
  task automatic wait_ticks(int n);
    repeat (n) begin
      @(negedge clk);
      while (bus.s_tick !== 1'b1) @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic v, int n);
    bus.rx = v;
    wait_ticks(n);
  endtask

  // stop_ticks < 16 drives the stop bit low/high only that long, then idles high.
  task automatic send_frame(logic [7:0] d, logic stop_v, int stop_ticks, logic par_bit);
    exp_a[wr_idx].d  = d;
    exp_a[wr_idx].fe = ~stop_v;
`ifdef UART_RX_PARITY_EN
    exp_a[wr_idx].pe = (par_bit != (^d));
`else
    exp_a[wr_idx].pe = 1'b0;
`endif
    wr_idx++;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit, 16);
`endif
    send_bit(stop_v, stop_ticks);
    if (stop_ticks < 16) send_bit(1'b1, 16 - stop_ticks);
  endtask

  task automatic wait_done(int k);
    for (int i = 0; i < 30000 && done_cnt < k; i++) @(negedge clk);
    if (done_cnt < k) to_cnt++;
  endtask

  initial begin
    bus.rx  = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pin(0, "reset_state", 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    wait_ticks(16);

    send_frame(8'hA5, 1'b1, 16, 1'b0);
    wait_done(1);
    pin(0, "a5_frame", 8'hA5, 1'b0, 1'b0);

    send_frame(8'h55, 1'b1, 16, 1'b0);
    send_frame(8'hC3, 1'b1, 16, 1'b0);
    wait_done(3);
    pin(0, "c3_after_55", 8'hC3, 1'b0, 1'b0);
    pin(2, "b2b_spacing", 8'h00, 1'b0, 1'b0);

    wait_ticks(8);
    send_bit(1'b0, 5);
    send_bit(1'b1, 24);
    pin(0, "glitch_no_change", 8'hC3, 1'b0, 1'b0);
    pin(1, "glitch_no_done", 8'h00, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b0, 12, 1'b0);
    wait_done(4);
    pin(0, "stop_low_ferr", 8'h3C, 1'b1, 1'b0);

    wait_ticks(8);
    send_frame(8'h81, 1'b1, 16, 1'b0);
    wait_done(5);
    pin(0, "ferr_cleared", 8'h81, 1'b0, 1'b0);

    // 0xFF cut short in the middle of data bit 4.
    send_bit(1'b0, 16);
    send_bit(1'b1, 4 * 16 + 8);
    reset_n = 1'b0;
    pin(0, "reset_midframe", 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    wait_ticks(16);

    send_frame(8'h12, 1'b1, 16, 1'b0);
    wait_done(6);
    pin(0, "after_reset", 8'h12, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 16, 1'b1);
    wait_done(7);
    pin(0, "parity_good", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 16, 1'b0);
    wait_done(8);
    pin(0, "parity_bad", 8'h07, 1'b0, 1'b1);
`endif

    wait_ticks(4);
    pin(1, "all_frames_done", 8'h00, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
